// File: rtl/serial_byte_deserializer_if.sv
// Byte hand-off bus between the serial deserializer and the byte queue.
// The deserializer drives byte_out/byte_valid (master); the queue answers with byte_ready (slave).
interface serial_byte_deserializer_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/serial_byte_deserializer.sv
// Serial byte deserializer: samples data_in on each rising edge of the asynchronous
// write_in strobe, packs bits MSB-first and offers each byte to the queue through a
// valid/ready handshake.
// Optional feature: define DEBOUNCE_EN to insert a stability filter on the
// synchronized write_in (DEBOUNCE_CYCLES equal samples before a level is accepted).
module serial_byte_deserializer #(
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clock_1MHz,
  input  logic                              rst,
  input  logic                              data_in,
  input  logic                              write_in,
  input  logic                              clear_err,
  serial_byte_deserializer_if.master        q_if,
  output logic                              status_out,
  output logic [2:0]                        bit_count,
  output logic                              frame_abort,
  output logic                              overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Reject configurations the synchronizer and filters cannot support.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("serial_byte_deserializer: invalid parameter value");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PEND  = 2'd2
  } state_e;

  // Synchronizer chains; fill marks which stages hold real samples rather than reset zeros.
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   wr_s;
  logic                   dat_s;

  // Recognised strobe level and the bit that goes with its rise.
  logic lvl;
  logic lvl_vld;
  logic bit_in;

  // Edge detection and arming.
  logic lvl_prev_q, lvl_prev_d;
  logic armed_q, armed_d;
  logic edge_q, edge_d;

  // Byte assembly state.
  state_e          state_q, state_d;
  logic [6:0]      shreg_q, shreg_d;
  logic [7:0]      byte_q, byte_d;
  logic            vld_q, vld_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic            abort_q, abort_d;
  logic            ovr_q, ovr_d;
  logic            status_q, status_d;

  assign wr_s  = wr_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Shift the asynchronous inputs through the synchronizer stages.
  always_comb begin
    wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], write_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], data_in};
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Synchronizer registers.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      wr_sync_q  <= '0;
      dat_sync_q <= '0;
      fill_q     <= '0;
    end else begin
      wr_sync_q  <= wr_sync_d;
      dat_sync_q <= dat_sync_d;
      fill_q     <= fill_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_raw_q, db_raw_d;
  logic          db_lvl_q, db_lvl_d;
  logic          db_vld_q, db_vld_d;
  logic          db_bit_q, db_bit_d;

  // Count consecutive equal samples; accept a level once it has been stable long enough.
  always_comb begin
    db_raw_d = wr_s;
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    db_vld_d = db_vld_q;
    db_bit_d = db_bit_q;
    if (!fill_q[SYNC_STAGES-1]) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == '0 || wr_s != db_raw_q) begin
      db_cnt_d = DW'(1);
    end else if (db_cnt_q != DW'(DEBOUNCE_CYCLES)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (db_cnt_d == DW'(DEBOUNCE_CYCLES)) begin
      db_vld_d = 1'b1;
      db_lvl_d = wr_s;
      // Data is captured the moment the debounced rise is recognised.
      if (wr_s && !db_lvl_q) begin
        db_bit_d = dat_s;
      end
    end
  end

  // Debounce filter registers.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      db_raw_q <= 1'b0;
      db_lvl_q <= 1'b0;
      db_vld_q <= 1'b0;
      db_bit_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_raw_q <= db_raw_d;
      db_lvl_q <= db_lvl_d;
      db_vld_q <= db_vld_d;
      db_bit_q <= db_bit_d;
    end
  end

  assign lvl     = db_lvl_q;
  assign lvl_vld = db_vld_q;
  assign bit_in  = db_bit_q;
`else
  assign lvl     = wr_s;
  assign lvl_vld = fill_q[SYNC_STAGES-1];
  assign bit_in  = dat_s;
`endif

  // Detect a rising strobe; only count it once a genuine low has been observed since reset.
  always_comb begin
    lvl_prev_d = lvl;
    armed_d    = armed_q | (lvl_vld & ~lvl);
    edge_d     = lvl_vld & lvl & ~lvl_prev_q & armed_q;
  end

  // Edge detection registers; the registered edge adds the one cycle of latency after the synchronizer.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      lvl_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      lvl_prev_q <= lvl_prev_d;
      armed_q    <= armed_d;
      edge_q     <= edge_d;
    end
  end

  // Byte assembly FSM: next state, shift register, handshake, timeout and error flags.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    abort_d = 1'b0;
    ovr_d   = ovr_q;
    if (clear_err) begin
      ovr_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          shreg_d = {shreg_q[5:0], bit_in};
          cnt_d   = 3'd1;
          to_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_q) begin
          to_d = '0;
          if (cnt_q == 3'd7) begin
            byte_d  = {shreg_q, bit_in};
            vld_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = PEND;
          end else begin
            shreg_d = {shreg_q[5:0], bit_in};
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Source went silent mid-byte: drop the partial byte and start over.
          shreg_d = '0;
          cnt_d   = 3'd0;
          to_d    = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      PEND: begin
        if (vld_q && q_if.byte_ready) begin
          vld_d = 1'b0;
          if (edge_q) begin
            // The slot frees this very cycle, so the new bit starts the next byte.
            shreg_d = {shreg_q[5:0], bit_in};
            cnt_d   = 3'd1;
            to_d    = '0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (edge_q) begin
          // New overrun wins over a coincident clear.
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    status_d = (state_d != PEND);
  end

  // FSM and datapath registers.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      byte_q   <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= 3'd0;
      to_q     <= '0;
      abort_q  <= 1'b0;
      ovr_q    <= 1'b0;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      byte_q   <= byte_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      abort_q  <= abort_d;
      ovr_q    <= ovr_d;
      status_q <= status_d;
    end
  end

  assign q_if.byte_out   = byte_q;
  assign q_if.byte_valid = vld_q;
  assign status_out      = status_q;
  assign bit_count       = cnt_q;
  assign frame_abort     = abort_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Directed bench for serial_byte_deserializer: a table of bytes sent with the queue
// ready, then hand-written sequences for back-pressure, timeout, reset with the strobe
// held high, transfer/strobe coincidence and strobe latency (plus glitch rejection
// when DEBOUNCE_EN is defined).
`timescale 1ns/1ps
module tb_serial_byte_deserializer;

  localparam int SYNC_STAGES = 2;
`ifdef DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + 1 + 4;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       clear_err = 1'b0;
  logic       status_out;
  logic [2:0] bit_count;
  logic       frame_abort;
  logic       overrun;

  serial_byte_deserializer_if q_if();

  serial_byte_deserializer #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYCLES(1000),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock_1MHz (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .clear_err  (clear_err),
    .q_if       (q_if),
    .status_out (status_out),
    .bit_count  (bit_count),
    .frame_abort(frame_abort),
    .overrun    (overrun)
  );

  always #500 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed activity, sampled with pre-edge values at each rising edge.
  int   vld_cycles = 0;
  int   xfers = 0;
  int   stat_low = 0;
  int   aborts = 0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk) begin
    if (q_if.byte_valid) begin
      vld_cycles <= vld_cycles + 1;
      last_byte  <= q_if.byte_out;
    end
    if (q_if.byte_valid && q_if.byte_ready) xfers <= xfers + 1;
    if (!status_out) stat_low <= stat_low + 1;
    if (frame_abort) aborts <= aborts + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe: 10 cycles high, 10 low. Called and returns at a falling edge.
  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    repeat (10) @(negedge clk);
    write_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [7:0] exp_byte;
    int         exp_vld;
    int         exp_stat_low;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  int v0, s0, x0, a0;

  initial begin
    vecs[0] = '{"byte_80", 8'b1000_0000, 8'h80, 1, 1, 3'd0};
    vecs[1] = '{"byte_01", 8'b0000_0001, 8'h01, 1, 1, 3'd0};
    vecs[2] = '{"byte_A5", 8'b1010_0101, 8'hA5, 1, 1, 3'd0};
    vecs[3] = '{"byte_FF", 8'b1111_1111, 8'hFF, 1, 1, 3'd0};
    vecs[4] = '{"byte_00", 8'b0000_0000, 8'h00, 1, 1, 3'd0};

    q_if.byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte_out", q_if.byte_out, 8'h00);
    chk("rst_byte_valid", q_if.byte_valid, 1'b0);
    chk("rst_bit_count", bit_count, 3'd0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_status", status_out, 1'b1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Bytes with the queue always ready: one-cycle valid and one-cycle status drop each.
    for (int i = 0; i < 5; i++) begin
      v0 = vld_cycles;
      s0 = stat_low;
      send_byte(vecs[i].data);
      repeat (5) @(negedge clk);
      chk({vecs[i].name, "_data"}, last_byte, vecs[i].exp_byte);
      chk({vecs[i].name, "_vld_cycles"}, vld_cycles - v0, vecs[i].exp_vld);
      chk({vecs[i].name, "_status_low"}, stat_low - s0, vecs[i].exp_stat_low);
      chk({vecs[i].name, "_bit_count"}, bit_count, vecs[i].exp_cnt);
    end

    // Back-pressure: second byte's strobes are dropped and flagged.
    q_if.byte_ready = 1'b0;
    send_byte(8'h80);
    chk("bp_valid", q_if.byte_valid, 1'b1);
    chk("bp_status", status_out, 1'b0);
    chk("bp_byte", q_if.byte_out, 8'h80);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b81;
      b81 = 8'h81;
      send_bit(b81[i]);
      chk("bp_overrun", overrun, 1'b1);
      chk("bp_cnt", bit_count, 3'd0);
    end
    chk("bp_byte_held", q_if.byte_out, 8'h80);
    x0 = xfers;
    q_if.byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_xfers", xfers - x0, 1);
    chk("bp_valid_after", q_if.byte_valid, 1'b0);
    chk("bp_status_after", status_out, 1'b1);
    chk("bp_overrun_sticky", overrun, 1'b1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    chk("clear_err", overrun, 1'b0);

    // Timeout of a 3-bit partial byte.
    a0 = aborts;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("to_partial_cnt", bit_count, 3'd3);
    for (int c = 0; c < 1100 && aborts == a0; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("to_abort_pulses", aborts - a0, 1);
    chk("to_cnt_cleared", bit_count, 3'd0);
    send_byte(8'h83);
    repeat (5) @(negedge clk);
    chk("to_next_byte", last_byte, 8'h83);

    // Reset mid-byte with the strobe held high across release.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("rs_partial_cnt", bit_count, 3'd5);
    data_in  = 1'b1;
    write_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_byte_out", q_if.byte_out, 8'h00);
    chk("rs_bit_count", bit_count, 3'd0);
    chk("rs_status", status_out, 1'b1);
    chk("rs_valid", q_if.byte_valid, 1'b0);
    chk("rs_overrun", overrun, 1'b0);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("rs_held_strobe_ignored", bit_count, 3'd0);
    write_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("rs_low_still_idle", bit_count, 3'd0);
    send_byte(8'hC3);
    repeat (5) @(negedge clk);
    chk("rs_next_byte", last_byte, 8'hC3);

    // Transfer and strobe edge in the same cycle.
    q_if.byte_ready = 1'b0;
    send_byte(8'h3C);
    chk("co_pending", status_out, 1'b0);
    x0 = xfers;
    data_in  = 1'b1;
    write_in = 1'b1;
    repeat (LAT) @(negedge clk);
    q_if.byte_ready = 1'b1;
    @(negedge clk);
    chk("co_xfers", xfers - x0, 1);
    chk("co_valid", q_if.byte_valid, 1'b0);
    chk("co_cnt", bit_count, 3'd1);
    chk("co_overrun", overrun, 1'b0);
    chk("co_status", status_out, 1'b1);
    chk("co_prev_byte", last_byte, 8'h3C);
    repeat (10 - LAT - 1) @(negedge clk);
    write_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] bb5;
      bb5 = 8'hB5;
      send_bit(bb5[i]);
    end
    repeat (5) @(negedge clk);
    chk("co_next_byte", last_byte, 8'hB5);

`ifdef DEBOUNCE_EN
    // Short glitch must not register as a strobe.
    write_in = 1'b1;
    repeat (2) @(negedge clk);
    write_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("db_glitch_ignored", bit_count, 3'd0);
`endif

    // Strobe-to-shift latency.
    data_in  = 1'b0;
    write_in = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("lat_before", bit_count, 3'd0);
    @(negedge clk);
    chk("lat_after", bit_count, 3'd1);
    repeat (10) @(negedge clk);
    write_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
